// File: rtl/iq_mixer_pkg.sv
// Shared mode encodings, product-width helper and parameter legality checks for the IQ mixer.
// Mode 3 is reserved and decodes as a plain mix wherever it is used.
package iq_mixer_pkg;

   localparam logic [1:0] MODE_MIX  = 2'd0;
   localparam logic [1:0] MODE_CONJ = 2'd1;
   localparam logic [1:0] MODE_BYP  = 2'd2;

   // The extra bit lets the negated most-negative product stay representable.
   function automatic int prod_w(input int in_w, input int nco_w);
      return in_w + nco_w + 1;
   endfunction

   function automatic bit params_ok(input int in_w, input int nco_w,
                                    input int out_w, input int shift);
      return (out_w >= in_w) && (shift >= 1) &&
             (shift < prod_w(in_w, nco_w)) && (out_w <= prod_w(in_w, nco_w));
   endfunction

endpackage

// File: rtl/iq_round_sat.sv
// Rounds a full-precision product (round half toward +inf), range-checks it against OUT_W,
// and either clamps (IQ_MIXER_SAT_EN defined) or wraps to the low OUT_W bits.
module iq_round_sat
   import iq_mixer_pkg::*;
#(
   parameter int PW    = 37,
   parameter int SHIFT = 15,
   parameter int OUT_W = 20
) (
   input  logic [PW-1:0]    p_i,
   output logic [OUT_W-1:0] r_o,
   output logic             ovf_o
);

   localparam int RW = PW + 1;

   logic signed [RW-1:0] p_ext;
   logic signed [RW-1:0] r_full;
   logic [RW-OUT_W:0]    top_bits;

   assign p_ext    = $signed({p_i[PW-1], p_i});
   assign r_full   = (p_ext >>> SHIFT) + $signed({{(RW-1){1'b0}}, p_i[SHIFT-1]});
   // In range exactly when every bit from the OUT_W sign bit upward agrees.
   assign top_bits = r_full[RW-1:OUT_W-1];
   assign ovf_o    = !((&top_bits) || !(|top_bits));

`ifdef IQ_MIXER_SAT_EN
   always_comb begin
      r_o = r_full[OUT_W-1:0];
      if (ovf_o) begin
         r_o = r_full[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
   end
`else
   assign r_o = r_full[OUT_W-1:0];
`endif

endmodule

// File: rtl/iq_mixer_pipe.sv
// Real-to-IQ mixer: 3-stage pipeline (register, multiply, round/range-check) with mode select
// and a saturating overflow counter. Define IQ_MIXER_SAT_EN to clamp instead of wrap.
module iq_mixer_pipe
   import iq_mixer_pkg::*;
#(
   parameter int IN_W      = 16,
   parameter int NCO_W     = 20,
   parameter int OUT_W     = 20,
   parameter int SHIFT     = 15,
   parameter int OVF_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [IN_W-1:0]      in,
   input  logic [NCO_W-1:0]     nco_i,
   input  logic [NCO_W-1:0]     nco_q,
   input  logic [1:0]           mode,
   input  logic                 ovf_clr,
   output logic                 o_valid,
   output logic [OUT_W-1:0]     o_i,
   output logic [OUT_W-1:0]     o_q,
   output logic                 o_ovf,
   output logic [OVF_CNT_W-1:0] ovf_cnt
);

   localparam int PW = prod_w(IN_W, NCO_W);

   generate
      if (!params_ok(IN_W, NCO_W, OUT_W, SHIFT)) begin : g_bad_params
         $error("iq_mixer_pipe: illegal IN_W/NCO_W/OUT_W/SHIFT combination");
      end
   endgenerate

   logic             s1_vld_q;
   logic [IN_W-1:0]  s1_smp_q;
   logic [NCO_W-1:0] s1_nco_i_q, s1_nco_q_q;
   logic [1:0]       s1_mode_q;

   logic             s2_vld_q;
   logic [PW-1:0]    s2_p_i_q, s2_p_q_q;
   logic [PW-1:0]    s2_p_i_d, s2_p_q_d;
   logic             s2_byp_q;
   logic [IN_W-1:0]  s2_smp_q;

   logic [OUT_W-1:0]     r_i, r_q;
   logic                 ovf_i, ovf_q;
   logic [OUT_W-1:0]     o_i_d, o_q_d;
   logic                 o_ovf_d;
   logic                 o_valid_q, o_ovf_q;
   logic [OUT_W-1:0]     o_i_q, o_q_q;
   logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

   // S1: capture the sample and its controls; data only moves with a valid sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q   <= 1'b0;
         s1_smp_q   <= '0;
         s1_nco_i_q <= '0;
         s1_nco_q_q <= '0;
         s1_mode_q  <= MODE_MIX;
      end else begin
         s1_vld_q <= in_valid;
         if (in_valid) begin
            s1_smp_q   <= in;
            s1_nco_i_q <= nco_i;
            s1_nco_q_q <= nco_q;
            s1_mode_q  <= mode;
         end
      end
   end

   always_comb begin
      s2_p_i_d = PW'($signed(s1_smp_q) * $signed(s1_nco_i_q));
      s2_p_q_d = PW'($signed(s1_smp_q) * $signed(s1_nco_q_q));
      if (s1_mode_q == MODE_CONJ) begin
         s2_p_q_d = -s2_p_q_d;
      end
   end

   // S2: full-precision products; the raw sample rides along for bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_q <= 1'b0;
         s2_p_i_q <= '0;
         s2_p_q_q <= '0;
         s2_byp_q <= 1'b0;
         s2_smp_q <= '0;
      end else begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            s2_p_i_q <= s2_p_i_d;
            s2_p_q_q <= s2_p_q_d;
            s2_byp_q <= (s1_mode_q == MODE_BYP);
            s2_smp_q <= s1_smp_q;
         end
      end
   end

   iq_round_sat #(.PW(PW), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rnd_i (
      .p_i  (s2_p_i_q),
      .r_o  (r_i),
      .ovf_o(ovf_i)
   );

   iq_round_sat #(.PW(PW), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rnd_q (
      .p_i  (s2_p_q_q),
      .r_o  (r_q),
      .ovf_o(ovf_q)
   );

   always_comb begin
      o_i_d   = r_i;
      o_q_d   = r_q;
      o_ovf_d = ovf_i | ovf_q;
      if (s2_byp_q) begin
         o_i_d   = OUT_W'($signed(s2_smp_q));
         o_q_d   = '0;
         o_ovf_d = 1'b0;
      end
   end

   // Clear has priority over a same-cycle overflow event.
   always_comb begin
      cnt_d = cnt_q;
      if (ovf_clr) begin
         cnt_d = '0;
      end else if (o_valid_q && o_ovf_q && !(&cnt_q)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // S3: outputs hold their last value across bubbles; o_ovf is only ever high with o_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid_q <= 1'b0;
         o_i_q     <= '0;
         o_q_q     <= '0;
         o_ovf_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         o_valid_q <= s2_vld_q;
         o_ovf_q   <= s2_vld_q & o_ovf_d;
         cnt_q     <= cnt_d;
         if (s2_vld_q) begin
            o_i_q <= o_i_d;
            o_q_q <= o_q_d;
         end
      end
   end

   assign o_valid = o_valid_q;
   assign o_i     = o_i_q;
   assign o_q     = o_q_q;
   assign o_ovf   = o_ovf_q;
   assign ovf_cnt = cnt_q;

endmodule

// File: tb/tb_iq_mixer_pipe.sv
// Self-checking bench for iq_mixer_pipe: directed spec cases plus random traffic checked
// against an arithmetic reference model with a time-stamped expected queue.
module tb_iq_mixer_pipe;

   localparam int IN_W      = 16;
   localparam int NCO_W     = 20;
   localparam int OUT_W     = 20;
   localparam int SHIFT     = 15;
   localparam int OVF_CNT_W = 16;
   localparam longint OUT_MAX = (64'sd1 <<< (OUT_W - 1)) - 1;
   localparam longint OUT_MIN = -(64'sd1 <<< (OUT_W - 1));
   localparam longint CNT_MAX = (64'sd1 <<< OVF_CNT_W) - 1;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic [IN_W-1:0]      in;
   logic [NCO_W-1:0]     nco_i;
   logic [NCO_W-1:0]     nco_q;
   logic [1:0]           mode;
   logic                 ovf_clr;
   logic                 o_valid;
   logic [OUT_W-1:0]     o_i;
   logic [OUT_W-1:0]     o_q;
   logic                 o_ovf;
   logic [OVF_CNT_W-1:0] ovf_cnt;

   iq_mixer_pipe #(
      .IN_W(IN_W), .NCO_W(NCO_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .OVF_CNT_W(OVF_CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .nco_i(nco_i), .nco_q(nco_q),
      .mode(mode), .ovf_clr(ovf_clr), .o_valid(o_valid), .o_i(o_i), .o_q(o_q),
      .o_ovf(o_ovf), .ovf_cnt(ovf_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      longint due;
      longint ei;
      longint eq;
      bit     eovf;
      bit     lit;
      longint li;
      longint lq;
      bit     lovf;
   } exp_t;

   exp_t   exp_q[$];
   int     n_vec = 0;
   int     n_err = 0;
   longint cyc = 0;
   longint cnt_m = 0;
   bit     prev_clr = 0;
   bit     prev_evt = 0;
   longint last_i = 0;
   longint last_q = 0;
   longint lit_i = 0;
   longint lit_q = 0;
   bit     lit_ovf = 0;

   task automatic check_val(input string tag, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Round half toward +inf: floor((p + 2^(SHIFT-1)) / 2^SHIFT).
   function automatic longint round_prod(input longint p);
      return (p + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
   endfunction

   function automatic longint fit_out(input longint r);
      longint w;
`ifdef IQ_MIXER_SAT_EN
      if (r > OUT_MAX) return OUT_MAX;
      if (r < OUT_MIN) return OUT_MIN;
      return r;
`else
      w = r & ((64'sd1 <<< OUT_W) - 1);
      if (w > OUT_MAX) w = w - (64'sd1 <<< OUT_W);
      return w;
`endif
   endfunction

   task automatic model_out(input longint s, input longint ni, input longint nq, input int m,
                            output longint ei, output longint eq, output bit eovf);
      longint pi, pq, ri, rq;
      if (m == 2) begin
         ei = s; eq = 0; eovf = 0;
      end else begin
         pi = s * ni;
         pq = s * nq;
         if (m == 1) pq = -pq;
         ri = round_prod(pi);
         rq = round_prod(pq);
         eovf = (ri > OUT_MAX) || (ri < OUT_MIN) || (rq > OUT_MAX) || (rq < OUT_MIN);
         ei = fit_out(ri);
         eq = fit_out(rq);
      end
   endtask

   // One clock: check what the DUT shows after this edge, then drive the next input.
   task automatic step(input bit v, input int s, input int ni, input int nq, input int m,
                       input bit clr, input bit lit);
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (prev_clr) cnt_m = 0;
      else if (prev_evt && cnt_m != CNT_MAX) cnt_m++;
      check_val("ovf_cnt", longint'(ovf_cnt), cnt_m);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check_val("o_valid", longint'(o_valid), 1);
         check_val("o_i", longint'($signed(o_i)), e.ei);
         check_val("o_q", longint'($signed(o_q)), e.eq);
         check_val("o_ovf", longint'(o_ovf), longint'(e.eovf));
         if (e.lit) begin
            check_val("dir_o_i", longint'($signed(o_i)), e.li);
            check_val("dir_o_q", longint'($signed(o_q)), e.lq);
            check_val("dir_o_ovf", longint'(o_ovf), longint'(e.lovf));
         end
         last_i   = e.ei;
         last_q   = e.eq;
         prev_evt = e.eovf;
      end else begin
         check_val("bubble_valid", longint'(o_valid), 0);
         check_val("hold_o_i", longint'($signed(o_i)), last_i);
         check_val("hold_o_q", longint'($signed(o_q)), last_q);
         check_val("bubble_ovf", longint'(o_ovf), 0);
         prev_evt = 0;
      end
      in_valid = v;
      in       = s[IN_W-1:0];
      nco_i    = ni[NCO_W-1:0];
      nco_q    = nq[NCO_W-1:0];
      mode     = m[1:0];
      ovf_clr  = clr;
      prev_clr = clr;
      if (v) begin
         e.due  = cyc + 3;
         model_out(longint'(s), longint'(ni), longint'(nq), m, e.ei, e.eq, e.eovf);
         e.lit  = lit;
         e.li   = lit_i;
         e.lq   = lit_q;
         e.lovf = lit_ovf;
         exp_q.push_back(e);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      cnt_m    = 0;
      prev_clr = 0;
      prev_evt = 0;
      last_i   = 0;
      last_q   = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_valid"}, longint'(o_valid), 0);
      check_val({tag, "_o_i"}, longint'($signed(o_i)), 0);
      check_val({tag, "_o_q"}, longint'($signed(o_q)), 0);
      check_val({tag, "_ovf"}, longint'(o_ovf), 0);
      check_val({tag, "_cnt"}, longint'(ovf_cnt), 0);
   endtask

   function automatic int rnd_in();
      logic [IN_W-1:0] r;
      r = IN_W'($urandom);
      return int'($signed(r));
   endfunction

   function automatic int rnd_nco();
      logic [NCO_W-1:0] r;
      case ($urandom_range(0, 3))
         0:       r = {1'b1, {(NCO_W-1){1'b0}}};
         1:       r = {1'b0, {(NCO_W-1){1'b1}}};
         default: r = NCO_W'($urandom);
      endcase
      return int'($signed(r));
   endfunction

   initial begin
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in       = '0;
      nco_i    = '0;
      nco_q    = '0;
      mode     = 2'd0;
      ovf_clr  = 1'b0;
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      model_reset();

      // Directed cases with literal expectations.
      lit_i = 1000; lit_q = -1000; lit_ovf = 0;
      step(1, 1000, 32768, -32768, 0, 0, 1);
      lit_i = 1; lit_q = 0; lit_ovf = 0;
      step(1, 1, 16384, 0, 0, 0, 1);
      lit_i = 0; lit_q = 0; lit_ovf = 0;
      step(1, -1, 16384, 0, 0, 0, 1);
`ifdef IQ_MIXER_SAT_EN
      lit_i = 524287;
`else
      lit_i = -524288;
`endif
      lit_q = 0; lit_ovf = 1;
      step(1, -32768, -524288, 0, 0, 0, 1);
      lit_i = 0; lit_q = -1000; lit_ovf = 0;
      step(1, 1000, 0, 32768, 1, 0, 1);
      lit_i = -5; lit_q = 0; lit_ovf = 0;
      step(1, -5, 12345, -777, 2, 0, 1);
      // Valid pattern 1,0,1,1 with held data across the bubble.
      step(1, 300, 65536, 98304, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, -700, 40000, -40000, 3, 0, 0);
      step(1, 123, -65536, 65536, 1, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0, 0, 0);

      // Clear and overflow event on the same clock: clear wins.
      step(1, -32768, -524288, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check_val("clr_wins", longint'(ovf_cnt), 0);

      // Random traffic, all modes, occasional clears.
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 3) != 0, rnd_in(), rnd_nco(), rnd_nco(),
              $urandom_range(0, 3), $urandom_range(0, 31) == 0, 0);
      end
      repeat (4) step(0, 0, 0, 0, 0, 0, 0);

      // Reset with samples in flight: nothing may emerge afterwards.
      step(1, 1000, 32768, 32768, 0, 0, 0);
      step(1, 2000, 32768, 32768, 0, 0, 0);
      step(1, 3000, 32768, 32768, 0, 0, 0);
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      #1 check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);

      // Saturating overflow counter.
      for (int k = 0; k < 65540; k++) begin
         step(1, -32768, -524288, 0, 0, 0, 0);
      end
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);
      check_val("cnt_sticks", longint'(ovf_cnt), CNT_MAX);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
